bit_alloc_pool: RTL and testbench



---
 rtl/bit_pool_pkg.sv | 55 +++++
 rtl/bit_find_index_p.sv | 39 +++
 rtl/bit_alloc_pool.sv | 143 ++++++++++++++
 tb/tb_bit_alloc_pool.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_pool_pkg.sv
// ============================================================
// Module  : bit_pool_pkg
// Brief   : Shared constants and mask helpers for bit_alloc_pool.
// Revision: 1.0 initial release
// ============================================================
`default_nettype none

package bit_pool_pkg;

    localparam int MAX_PORTS = 4;
    localparam int MAX_WIDTH = 256;

    function automatic logic [8:0] popcount(input logic [MAX_WIDTH-1:0] v);
        logic [8:0] n;
        n = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            n = n + 9'(v[i]);
        end
        return n;
    endfunction

    // Rotations act on the low w bits only; w must be a power of two.
    function automatic logic [MAX_WIDTH-1:0] rotr_mask(input logic [MAX_WIDTH-1:0] v,
                                                       input logic [7:0]           sh,
                                                       input int                   w);
        logic [MAX_WIDTH-1:0] r;
        logic [7:0]           src;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < w) begin
                src  = 8'((i + int'(sh)) & (w - 1));
                r[i] = v[src];
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] rotl_mask(input logic [MAX_WIDTH-1:0] v,
                                                       input logic [7:0]           sh,
                                                       input int                   w);
        logic [MAX_WIDTH-1:0] r;
        logic [7:0]           src;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < w) begin
                src  = 8'((i - int'(sh)) & (w - 1));
                r[i] = v[src];
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_find_index_p.sv
// ============================================================
// Module  : bit_find_index_p
// Brief   : First set bit of mask at or above start, wrapping.
// Revision: 1.0 initial release
// ============================================================
`default_nettype none

module bit_find_index_p
    import bit_pool_pkg::*;
#(
    parameter  int WIDTH = 64,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] mask,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             hasany
);

    logic [WIDTH-1:0] rot;
    logic [IDX_W-1:0] off;

    // Rotate start down to bit 0 so a plain priority search yields the offset.
    always_comb begin
        rot    = WIDTH'(rotr_mask(MAX_WIDTH'(mask), 8'(start), WIDTH));
        off    = '0;
        hasany = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off    = IDX_W'(i);
                hasany = 1'b1;
            end
        end
        idx = hasany ? (off + start) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/bit_alloc_pool.sv
// ============================================================
// Module  : bit_alloc_pool
// Brief   : Multi-port index allocator with occupancy count, flush and
//           double-free flag. BIT_POOL_RR_EN enables round-robin search.
// Revision: 1.0 initial release
// ============================================================
`default_nettype none

module bit_alloc_pool
    import bit_pool_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int PORTS = 2,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PORTS-1:0]       alloc_req,
    output logic [PORTS-1:0]       alloc_gnt,
    output logic [PORTS*IDX_W-1:0] alloc_idx,
    input  logic [PORTS-1:0]       free_vld,
    input  logic [PORTS*IDX_W-1:0] free_idx,
    input  logic                   flush,
    output logic [CNT_W-1:0]       free_cnt,
    output logic                   empty,
    output logic                   dbl_free_err
);

    logic [WIDTH-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
    logic             empty_q, empty_d;
    logic             err_q, err_d;

    logic [IDX_W-1:0] start;
    logic [WIDTH-1:0] mask [PORTS+1];
    logic [IDX_W-1:0] fidx [PORTS];
    logic [PORTS-1:0] hit;
    logic [PORTS-1:0] take;
    logic             gate;
    logic [WIDTH-1:0] grant_bits;
    logic [WIDTH-1:0] rel;
    logic             dbl;
    logic [IDX_W-1:0] ridx;

    assign gate    = rst_n & ~flush;
    assign mask[0] = ~busy_q;

    // Each port searches what the lower ports left behind.
    for (genvar p = 0; p < PORTS; p++) begin : g_port
        bit_find_index_p #(.WIDTH(WIDTH)) u_find (
            .mask   (mask[p]),
            .start  (start),
            .idx    (fidx[p]),
            .hasany (hit[p])
        );
        assign take[p]                     = alloc_req[p] & hit[p];
        assign mask[p+1]                   = take[p] ? (mask[p] & ~(WIDTH'(1) << fidx[p])) : mask[p];
        assign alloc_gnt[p]                = take[p] & gate;
        assign alloc_idx[p*IDX_W +: IDX_W] = alloc_gnt[p] ? fidx[p] : '0;
    end

    assign grant_bits = gate ? (mask[0] & ~mask[PORTS]) : '0;

    // A second release of the same index in one cycle counts as a double free.
    always_comb begin
        rel  = '0;
        dbl  = 1'b0;
        ridx = '0;
        for (int p = 0; p < PORTS && p < MAX_PORTS; p++) begin
            if (free_vld[p]) begin
                ridx = free_idx[p*IDX_W +: IDX_W];
                if (!busy_q[ridx] || rel[ridx]) begin
                    dbl = 1'b1;
                end else begin
                    rel[ridx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy_d     = (busy_q | grant_bits) & ~rel;
        free_cnt_d = free_cnt_q - CNT_W'(popcount(MAX_WIDTH'(alloc_gnt)))
                                + CNT_W'(popcount(MAX_WIDTH'(rel)));
        err_d      = err_q | dbl;
        if (flush) begin
            busy_d     = '0;
            free_cnt_d = CNT_W'(WIDTH);
            err_d      = err_q;
        end
        empty_d = (free_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            free_cnt_q <= CNT_W'(WIDTH);
            empty_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            free_cnt_q <= free_cnt_d;
            empty_q    <= empty_d;
            err_q      <= err_d;
        end
    end

`ifdef BIT_POOL_RR_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    assign start = rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int p = 0; p < PORTS; p++) begin
            if (alloc_gnt[p]) begin
                rr_ptr_d = fidx[p] + IDX_W'(1);
            end
        end
        if (flush) begin
            rr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign start = '0;
`endif

    assign free_cnt     = free_cnt_q;
    assign empty        = empty_q;
    assign dbl_free_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_alloc_pool.sv
// Self-checking bench for bit_alloc_pool (WIDTH=64, PORTS=2); follows
// BIT_POOL_RR_EN so the reference model searches the same way as the build.
`default_nettype none

module tb_bit_alloc_pool;

    localparam int WIDTH = 64;
    localparam int PORTS = 2;
    localparam int IDX_W = 6;
    localparam int CNT_W = 7;
`ifdef BIT_POOL_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [PORTS-1:0]       alloc_req = '0;
    logic [PORTS-1:0]       alloc_gnt;
    logic [PORTS*IDX_W-1:0] alloc_idx;
    logic [PORTS-1:0]       free_vld = '0;
    logic [PORTS*IDX_W-1:0] free_idx = '0;
    logic                   flush = 1'b0;
    logic [CNT_W-1:0]       free_cnt;
    logic                   empty;
    logic                   dbl_free_err;

    bit_alloc_pool #(.WIDTH(WIDTH), .PORTS(PORTS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_idx    (alloc_idx),
        .free_vld     (free_vld),
        .free_idx     (free_idx),
        .flush        (flush),
        .free_cnt     (free_cnt),
        .empty        (empty),
        .dbl_free_err (dbl_free_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PORTS-1:0]       gnt;
        logic [PORTS*IDX_W-1:0] idx;
        logic [CNT_W-1:0]       cnt;
        logic                   empty;
        logic                   err;
    } rec_t;

    rec_t sb[$];
    rec_t ob[$];

    bit m_busy [0:WIDTH-1];
    int m_cnt;
    bit m_err;
    int m_rr;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic model_reset();
        for (int i = 0; i < WIDTH; i++) m_busy[i] = 1'b0;
        m_cnt = WIDTH;
        m_err = 1'b0;
        m_rr  = 0;
    endtask

    // One clock: drive, predict, capture grants before the edge and state after.
    task automatic step(input logic [1:0] req, input logic [1:0] fv, input int f0, input int f1, input logic fl);
        rec_t e, o;
        bit   taken [0:WIDTH-1];
        bit   rel   [0:WIDTH-1];
        int   st, j;
        alloc_req = req;
        free_vld  = fv;
        free_idx  = {6'(f1), 6'(f0)};
        flush     = fl;
        e  = '0;
        st = RR ? m_rr : 0;
        for (int i = 0; i < WIDTH; i++) begin
            taken[i] = m_busy[i];
            rel[i]   = 1'b0;
        end
        if (!fl) begin
            for (int p = 0; p < PORTS; p++) begin
                if (req[p]) begin
                    for (int k = 0; k < WIDTH; k++) begin
                        j = (st + k) % WIDTH;
                        if (!e.gnt[p] && !taken[j]) begin
                            e.gnt[p] = 1'b1;
                            e.idx[p*IDX_W +: IDX_W] = 6'(j);
                            taken[j] = 1'b1;
                        end
                    end
                end
            end
        end
        if (fl) begin
            for (int i = 0; i < WIDTH; i++) m_busy[i] = 1'b0;
            m_cnt = WIDTH;
            m_rr  = 0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (fv[p]) begin
                    j = (p == 0) ? f0 : f1;
                    if (!m_busy[j] || rel[j]) m_err = 1'b1;
                    else begin
                        rel[j] = 1'b1;
                        m_cnt++;
                    end
                end
            end
            for (int p = 0; p < PORTS; p++) begin
                if (e.gnt[p]) begin
                    j = int'(e.idx[p*IDX_W +: IDX_W]);
                    m_busy[j] = 1'b1;
                    m_cnt--;
                    m_rr = (j + 1) % WIDTH;
                end
            end
            for (int i = 0; i < WIDTH; i++) if (rel[i]) m_busy[i] = 1'b0;
        end
        e.cnt   = 7'(m_cnt);
        e.empty = (m_cnt == 0);
        e.err   = m_err;
        sb.push_back(e);
        #1;
        o       = '0;
        o.gnt   = alloc_gnt;
        o.idx   = alloc_idx;
        @(posedge clk);
        #1;
        o.cnt   = free_cnt;
        o.empty = empty;
        o.err   = dbl_free_err;
        ob.push_back(o);
        alloc_req = '0;
        free_vld  = '0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        alloc_req = '0;
        free_vld  = '0;
        free_idx  = '0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        alloc_req = 2'b11;
        #1;
        n_tests++;
        if (alloc_gnt !== 2'b00 || alloc_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_gnt: gnt=%b idx=%h, expected gnt=00 idx=000", alloc_gnt, alloc_idx);
        end
        do_reset();
        n_tests++;
        if (free_cnt !== 7'd64 || empty !== 1'b0 || dbl_free_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: cnt=%0d empty=%b err=%b, expected cnt=64 empty=0 err=0", free_cnt, empty, dbl_free_err);
        end
    endtask

    task automatic test_basic_alloc();
        rec_t e, o;
        do_reset();
        step(2'b11, 2'b00, 0, 0, 1'b0);
        o = ob[$];
        n_tests++;
        if (o.gnt !== 2'b11 || o.idx !== {6'd1, 6'd0} || o.cnt !== 7'd62) begin
            n_fail++;
            $display("FAIL basic_first: gnt=%b idx=%h cnt=%0d, expected gnt=11 idx=040 cnt=62", o.gnt, o.idx, o.cnt);
        end
        step(2'b10, 2'b00, 0, 0, 1'b0);
        step(2'b01, 2'b00, 0, 0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL basic: gnt=%b idx=%h cnt=%0d empty=%b err=%b, expected gnt=%b idx=%h cnt=%0d empty=%b err=%b",
                         o.gnt, o.idx, o.cnt, o.empty, o.err, e.gnt, e.idx, e.cnt, e.empty, e.err);
            end
        end
    endtask

    task automatic test_fill_and_release();
        rec_t e, o;
        do_reset();
        for (int i = 0; i < WIDTH / 2; i++) step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b11, 2'b00, 0, 0, 1'b0);
        o = ob[$];
        n_tests++;
        if (o.gnt !== 2'b00 || o.empty !== 1'b1 || o.cnt !== 7'd0) begin
            n_fail++;
            $display("FAIL full_pool: gnt=%b empty=%b cnt=%0d, expected gnt=00 empty=1 cnt=0", o.gnt, o.empty, o.cnt);
        end
        step(2'b00, 2'b01, 37, 0, 1'b0);
        step(2'b11, 2'b00, 0, 0, 1'b0);
        o = ob[$];
        n_tests++;
        if (o.gnt !== 2'b01 || o.idx[5:0] !== 6'd37 || o.idx[11:6] !== 6'd0) begin
            n_fail++;
            $display("FAIL refill_37: gnt=%b idx=%h, expected gnt=01 idx0=37 idx1=0", o.gnt, o.idx);
        end
        step(2'b00, 2'b00, 0, 0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL fill: gnt=%b idx=%h cnt=%0d empty=%b err=%b, expected gnt=%b idx=%h cnt=%0d empty=%b err=%b",
                         o.gnt, o.idx, o.cnt, o.empty, o.err, e.gnt, e.idx, e.cnt, e.empty, e.err);
            end
        end
    endtask

    task automatic test_dbl_free();
        rec_t e, o;
        do_reset();
        step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b11, 0, 0, 1'b0);
        o = ob[$];
        n_tests++;
        if (o.err !== 1'b1 || o.cnt !== 7'd63) begin
            n_fail++;
            $display("FAIL same_cycle_dup: err=%b cnt=%0d, expected err=1 cnt=63", o.err, o.cnt);
        end
        do_reset();
        step(2'b00, 2'b01, 5, 0, 1'b0);
        o = ob[$];
        n_tests++;
        if (o.err !== 1'b1 || o.cnt !== 7'd64) begin
            n_fail++;
            $display("FAIL free_unused_5: err=%b cnt=%0d, expected err=1 cnt=64", o.err, o.cnt);
        end
        step(2'b00, 2'b00, 0, 0, 1'b1);
        step(2'b00, 2'b00, 0, 0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL dbl_free: gnt=%b idx=%h cnt=%0d empty=%b err=%b, expected gnt=%b idx=%h cnt=%0d empty=%b err=%b",
                         o.gnt, o.idx, o.cnt, o.empty, o.err, e.gnt, e.idx, e.cnt, e.empty, e.err);
            end
        end
    endtask

    task automatic test_flush();
        rec_t e, o;
        do_reset();
        step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b11, 2'b01, 10, 0, 1'b1);
        o = ob[$];
        n_tests++;
        if (o.gnt !== 2'b00 || o.cnt !== 7'd64 || o.err !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: gnt=%b cnt=%0d err=%b, expected gnt=00 cnt=64 err=0", o.gnt, o.cnt, o.err);
        end
        step(2'b11, 2'b00, 0, 0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL flush: gnt=%b idx=%h cnt=%0d empty=%b err=%b, expected gnt=%b idx=%h cnt=%0d empty=%b err=%b",
                         o.gnt, o.idx, o.cnt, o.empty, o.err, e.gnt, e.idx, e.cnt, e.empty, e.err);
            end
        end
    endtask

    task automatic test_search_order();
        rec_t e, o;
        do_reset();
        step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b11, 0, 1, 1'b0);
        step(2'b11, 2'b00, 0, 0, 1'b0);
        do_reset();
        for (int i = 0; i < 31; i++) step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b01, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b01, 0, 0, 1'b0);
        step(2'b11, 2'b00, 0, 0, 1'b0);
        o = ob[$];
        n_tests++;
        if (o.gnt !== 2'b11 || o.idx !== (RR ? {6'd0, 6'd63} : {6'd63, 6'd0})) begin
            n_fail++;
            $display("FAIL wrap_grant: gnt=%b idx=%h, expected gnt=11 idx=%h", o.gnt, o.idx, RR ? {6'd0, 6'd63} : {6'd63, 6'd0});
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL search: gnt=%b idx=%h cnt=%0d empty=%b err=%b, expected gnt=%b idx=%h cnt=%0d empty=%b err=%b",
                         o.gnt, o.idx, o.cnt, o.empty, o.err, e.gnt, e.idx, e.cnt, e.empty, e.err);
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t       e, o;
        logic [1:0] req, fv;
        int         fi [2];
        int         s;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            req = 2'($urandom_range(0, 3));
            fv  = '0;
            for (int p = 0; p < 2; p++) begin
                fi[p] = int'($urandom_range(0, WIDTH - 1));
                if ($urandom_range(0, 2) != 0) begin
                    fv[p] = 1'b1;
                    if ($urandom_range(0, 15) != 0) begin
                        s = fi[p];
                        for (int k = 0; k < WIDTH; k++) begin
                            if (m_busy[(s + k) % WIDTH] && !m_busy[fi[p]]) fi[p] = (s + k) % WIDTH;
                        end
                    end
                end
            end
            step(req, fv, fi[0], fi[1], ($urandom_range(0, 24) == 0));
            e = sb.pop_front();
            o = ob.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d]: gnt=%b idx=%h cnt=%0d empty=%b err=%b, expected gnt=%b idx=%h cnt=%0d empty=%b err=%b",
                         n, o.gnt, o.idx, o.cnt, o.empty, o.err, e.gnt, e.idx, e.cnt, e.empty, e.err);
            end
        end
    endtask

    task automatic test_reset_mid();
        rec_t e, o;
        do_reset();
        step(2'b11, 2'b00, 0, 0, 1'b0);
        alloc_req = 2'b11;
        #1;
        n_tests++;
        if (alloc_gnt !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_pre: gnt=%b, expected gnt=11", alloc_gnt);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (alloc_gnt !== 2'b00 || free_cnt !== 7'd64) begin
            n_fail++;
            $display("FAIL mid_async: gnt=%b cnt=%0d, expected gnt=00 cnt=64", alloc_gnt, free_cnt);
        end
        @(posedge clk);
        #1;
        alloc_req = '0;
        rst_n     = 1'b1;
        model_reset();
        n_tests++;
        if (free_cnt !== 7'd64 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: cnt=%0d empty=%b, expected cnt=64 empty=0", free_cnt, empty);
        end
        step(2'b11, 2'b00, 0, 0, 1'b0);
        e = sb.pop_front();
        o = ob.pop_front();
        n_tests++;
        if (o !== e || o.idx !== {6'd1, 6'd0}) begin
            n_fail++;
            $display("FAIL mid_regrant: gnt=%b idx=%h cnt=%0d, expected gnt=%b idx=%h cnt=%0d", o.gnt, o.idx, o.cnt, e.gnt, e.idx, e.cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_alloc();
        test_fill_and_release();
        test_dbl_free();
        test_flush();
        test_search_order();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion within 2000000 time units");
        $fatal(1);
    end

endmodule

`default_nettype wire
